dec_key_controller: RTL and testbench

- Front-end sequencer for the decimal-to-BCD encoding path.
- Synchronises 10 raw decimal key lines, debounces them, and rejects multi-key presses.
- Encodes each clean one-hot press to a 4-bit BCD digit and queues it in a small FIFO.
- Delivers digits downstream over a valid/ready handshake.

---
 rtl/dec_key_pkg.sv | 40 ++++
 rtl/dec_key_fifo.sv | 87 ++++++++
 rtl/dec_key_controller.sv | 190 +++++++++++++++++++
 tb/tb_dec_key_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_key_pkg.sv
// -----------------------------------------------------------------------------
// dec_key_pkg
// Shared types and helpers for the decimal key front-end.
//   KEY_W    : number of raw decimal key lines (digits 0..9)
//   DIGIT_W  : width of an encoded BCD digit
//   state_e  : key sequencer states
//   onehot_to_bcd : index of the single set bit of a key vector
//   is_onehot     : true when exactly one key bit is set
// -----------------------------------------------------------------------------
package dec_key_pkg;

   localparam int KEY_W   = 10;
   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   // Index of the set bit; only meaningful for one-hot input, result is 0..9.
   function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] vec);
      logic [DIGIT_W-1:0] idx;
      idx = 4'd0;
      for (int i = 0; i < KEY_W; i++) begin
         if (vec[i]) begin
            idx = DIGIT_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Non-zero and clearing the lowest set bit leaves nothing behind.
   function automatic logic is_onehot(input logic [KEY_W-1:0] vec);
      return (vec != 10'd0) && ((vec & (vec - 10'd1)) == 10'd0);
   endfunction

endpackage

// File: rtl/dec_key_fifo.sv
// -----------------------------------------------------------------------------
// dec_key_fifo
// Small synchronous FIFO for encoded digits with a valid/ready read side.
// A push while full (and no pop in the same cycle) is dropped and flagged by
// a one-cycle overflow pulse; the stored contents are left untouched.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write request, wr_data is the entry
//   pop_ready    : consumer ready; an entry leaves when rd_valid & pop_ready
//   rd_data      : head entry, 0 when empty
//   rd_valid     : FIFO non-empty
//   overflow     : registered pulse, a push was dropped
// -----------------------------------------------------------------------------
module dec_key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             overflow_r;

   logic full_s;
   logic pop_s;
   logic wr_en_s;
   logic drop_s;

   assign rd_valid = (count_r != '0);
   assign full_s   = (count_r == CNT_FULL);
   assign pop_s    = rd_valid & pop_ready;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign wr_en_s  = push & (~full_s | pop_s);
   assign drop_s   = push & full_s & ~pop_s;
   assign rd_data  = rd_valid ? mem_r[rd_ptr_r] : '0;
   assign overflow = overflow_r;

   // Storage array; contents are don't-care while not counted as occupied.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointers (wrap naturally, DEPTH is a power of 2), occupancy and overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= drop_s;
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
            2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/dec_key_controller.sv
// -----------------------------------------------------------------------------
// dec_key_controller
// Key front-end: synchronises 10 raw decimal key lines, debounces press and
// release, rejects multi-key patterns, encodes a clean press to BCD and queues
// it for a valid/ready consumer.
// Optional feature: define KEY_REPEAT_EN to re-push a held digit every
// REPEAT_CYCLES cycles of an unchanged single-key hold.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_in       : raw key lines, bit i = digit i, asynchronous to clk
//   digit_out    : BCD digit at the queue head, 0 when empty
//   digit_valid  : queue non-empty
//   digit_ready  : consumer accepts the head digit
//   err_multi    : pulse, debounced pattern had more than one key set
//   overflow     : pulse, accepted digit dropped because the queue was full
//   busy         : sequencer not idle
// -----------------------------------------------------------------------------
module dec_key_controller
   import dec_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_W-1:0]   key_in,
   output logic [DIGIT_W-1:0] digit_out,
   output logic               digit_valid,
   input  logic               digit_ready,
   output logic               err_multi,
   output logic               overflow,
   output logic               busy
);

   if (DEBOUNCE_CYCLES < 32'sd2 || FIFO_DEPTH < 32'sd2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0 || REPEAT_CYCLES < 32'sd1) begin : g_bad_params
      $error("dec_key_controller: illegal parameter set");
   end

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [KEY_W-1:0] sync1_r;
   logic [KEY_W-1:0] ks_r;

   state_e           state_r;
   state_e           state_nx;
   logic [KEY_W-1:0] snap_r;
   logic [KEY_W-1:0] snap_nx;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx;
   logic             push_s;
   logic             err_s;
   logic             err_r;
   logic             busy_r;

`ifdef KEY_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] rpt_r;
   logic [RPT_W-1:0] rpt_nx;
`endif

   // Two-flop synchroniser; the sequencer only ever looks at ks_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= '0;
         ks_r    <= '0;
      end else begin
         sync1_r <= key_in;
         ks_r    <= sync1_r;
      end
   end

   // Sequencer next-state, counters and push/error decisions.
   always_comb begin
      state_nx = state_r;
      snap_nx  = snap_r;
      cnt_nx   = cnt_r;
      push_s   = 1'b0;
      err_s    = 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_nx   = rpt_r;
`endif
      case (state_r)
         IDLE: begin
            if (ks_r != 10'd0) begin
               snap_nx  = ks_r;
               cnt_nx   = '0;
               state_nx = DEBOUNCE;
            end else begin
               state_nx = IDLE;
            end
         end
         DEBOUNCE: begin
            if (ks_r == 10'd0) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (ks_r != snap_r) begin
               // Pattern moved before it settled: restart on the new pattern.
               snap_nx = ks_r;
               cnt_nx  = '0;
            end else if (cnt_r == CNT_LAST) begin
               if (is_onehot(snap_r)) begin
                  push_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
               cnt_nx   = '0;
               state_nx = HELD;
`ifdef KEY_REPEAT_EN
               rpt_nx   = '0;
`endif
            end else begin
               cnt_nx = cnt_r + CNT_W'(1);
            end
         end
         HELD: begin
            // Any key activity restarts the release qualification, so a new
            // key cannot be accepted until everything has been let go.
            if (ks_r != 10'd0) begin
               cnt_nx = '0;
            end else if (cnt_r == CNT_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt_r + CNT_W'(1);
            end
`ifdef KEY_REPEAT_EN
            if (ks_r == snap_r) begin
               if (rpt_r == RPT_LAST) begin
                  rpt_nx = '0;
                  push_s = is_onehot(snap_r);
               end else begin
                  rpt_nx = rpt_r + RPT_W'(1);
               end
            end else begin
               rpt_nx = '0;
            end
`endif
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // Sequencer state, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         snap_r  <= '0;
         cnt_r   <= '0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
`ifdef KEY_REPEAT_EN
         rpt_r   <= '0;
`endif
      end else begin
         state_r <= state_nx;
         snap_r  <= snap_nx;
         cnt_r   <= cnt_nx;
         err_r   <= err_s;
         busy_r  <= (state_nx != IDLE);
`ifdef KEY_REPEAT_EN
         rpt_r   <= rpt_nx;
`endif
      end
   end

   dec_key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DIGIT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .wr_data   (onehot_to_bcd(snap_r)),
      .pop_ready (digit_ready),
      .rd_data   (digit_out),
      .rd_valid  (digit_valid),
      .overflow  (overflow)
   );

   assign err_multi = err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_dec_key_controller.sv
// -----------------------------------------------------------------------------
// tb_dec_key_controller
// Directed stimulus with a digit scoreboard: the stimulus pushes the digits it
// expects, a negedge monitor pops and compares every accepted digit, and also
// tallies err_multi / overflow pulses for the stimulus to compare.
// -----------------------------------------------------------------------------
module tb_dec_key_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] key_in = 10'd0;
   logic       digit_ready = 1'b0;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       err_multi;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int pops = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   logic [3:0] exp_q[$];

   dec_key_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .digit_out   (digit_out),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .err_multi   (err_multi),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares every handshaken digit against the scoreboard.
   always @(negedge clk) begin
      if (err_multi) err_cnt++;
      if (overflow) ovf_cnt++;
      if (digit_valid && digit_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            check("unexpected_digit", int'(digit_out), -1);
         end else begin
            check("digit_order", int'(digit_out), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int bound);
      for (int i = 0; i < bound && busy; i++) tick(1);
      check(name, int'(busy), 0);
   endtask

   task automatic press_release(input int d, input int hold, input int rel);
      key_in = 10'd1 << d;
      tick(hold);
      key_in = 10'd0;
      tick(rel);
   endtask

   int p0, e0, o0, nrep;

   initial begin
      // Reset state
      tick(3);
      check("rst_digit_out", int'(digit_out), 0);
      check("rst_valid", int'(digit_valid), 0);
      check("rst_err", int'(err_multi), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick(2);

      // Key 3 held 20 cycles: one digit, valid first seen after edge 7
      digit_ready = 1'b1;
      p0 = pops;
      exp_q.push_back(4'd3);
      key_in = 10'b0000001000;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("latency_before_edge7", int'(digit_valid), 0);
      @(posedge clk);
      @(negedge clk);
      check("latency_edge7_valid", int'(digit_valid), 1);
      check("latency_edge7_digit", int'(digit_out), 3);
      @(posedge clk);
      @(negedge clk);
      check("valid_one_cycle", int'(digit_valid), 0);
      tick(12);
      key_in = 10'd0;
      wait_idle("idle_after_key3", 40);
      check("key3_count", pops - p0, 1);

      // Key 5 bouncing, then held
      p0 = pops;
      e0 = err_cnt;
      exp_q.push_back(4'd5);
      for (int i = 0; i < 2; i++) begin
         key_in = 10'b0000100000;
         tick(2);
         key_in = 10'd0;
         tick(2);
      end
      key_in = 10'b0000100000;
      tick(20);
      key_in = 10'd0;
      wait_idle("idle_after_key5", 40);
      check("key5_count", pops - p0, 1);
      check("key5_no_err", err_cnt - e0, 0);

      // Keys 2 and 7 together
      p0 = pops;
      e0 = err_cnt;
      key_in = 10'b0010000100;
      tick(20);
      check("multi_err_once", err_cnt - e0, 1);
      check("multi_busy_held", int'(busy), 1);
      key_in = 10'd0;
      wait_idle("idle_after_multi", 40);
      check("multi_no_digit", pops - p0, 0);
      check("multi_valid_low", int'(digit_valid), 0);

      // Fill with ready low; fifth press overflows
      digit_ready = 1'b0;
      p0 = pops;
      o0 = ovf_cnt;
      e0 = err_cnt;
      for (int d = 1; d <= 5; d++) begin
         if (d <= 4) exp_q.push_back(4'(d));
         press_release(d, 10, 10);
         check("ovf_progress", ovf_cnt - o0, (d == 5) ? 1 : 0);
      end
      check("full_valid", int'(digit_valid), 1);
      check("full_head", int'(digit_out), 1);
      check("full_no_err", err_cnt - e0, 0);
      digit_ready = 1'b1;
      tick(10);
      check("drain_count", pops - p0, 4);
      check("drain_valid_low", int'(digit_valid), 0);
      check("drain_scoreboard_empty", exp_q.size(), 0);

      // Reset in the middle of a debounce with two digits queued
      digit_ready = 1'b0;
      exp_q.push_back(4'd6);
      press_release(6, 10, 10);
      exp_q.push_back(4'd8);
      press_release(8, 10, 10);
      check("queued_head", int'(digit_out), 6);
      key_in = 10'b0000001000;
      tick(4);
      check("mid_debounce_busy", int'(busy), 1);
      check("mid_debounce_valid", int'(digit_valid), 0 + 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", int'(digit_valid), 0);
      check("async_rst_digit", int'(digit_out), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_err", int'(err_multi), 0);
      check("async_rst_ovf", int'(overflow), 0);
      exp_q.delete();
      exp_q.push_back(4'd3);
      p0 = pops;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(4);
      check("fresh_debounce_pending", int'(digit_valid), 0);
      tick(8);
      check("fresh_debounce_head", int'(digit_out), 3);
      digit_ready = 1'b1;
      tick(3);
      key_in = 10'd0;
      wait_idle("idle_after_reset", 40);
      check("after_reset_count", pops - p0, 1);

      // Key 9 held 60 cycles
`ifdef KEY_REPEAT_EN
      nrep = 4;
`else
      nrep = 1;
`endif
      p0 = pops;
      for (int i = 0; i < nrep; i++) exp_q.push_back(4'd9);
      key_in = 10'b1000000000;
      tick(60);
      key_in = 10'd0;
      wait_idle("idle_after_key9", 40);
      tick(5);
      check("key9_count", pops - p0, nrep);
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
